// File: rtl/psc_trigger_rx.sv
// PSC trigger receiver: delineates fixed-length frames from the deserialized byte stream,
// verifies the XOR checksum, and reports trigger pulses plus link-health status.
module psc_trigger_rx #(
    parameter int          FRAME_BYTES  = 10,
    parameter logic [7:0]  IDLE_HDR     = 8'hA5,
    parameter logic [7:0]  TRIG_HDR     = 8'h5A,
    parameter int          BYTE_TIMEOUT = 64,
    parameter int          LOCK_COUNT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        trigger_out,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        locked,
    output logic [15:0] trig_count,
    output logic [15:0] err_count
);

    localparam int IDX_W  = $clog2(FRAME_BYTES);
    localparam int GAP_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  byte_idx, byte_idx_nxt;
    logic [7:0]        csum, csum_nxt;
    logic              is_trig, is_trig_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [LOCK_W-1:0] good_cnt, good_cnt_nxt;

    logic              trigger_nxt, frame_ok_nxt, frame_err_nxt, locked_nxt;
    logic [15:0]       trig_count_nxt, err_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            byte_idx    <= '0;
            csum        <= '0;
            is_trig     <= 1'b0;
            gap_cnt     <= '0;
            good_cnt    <= '0;
            trigger_out <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            trig_count  <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            byte_idx    <= byte_idx_nxt;
            csum        <= csum_nxt;
            is_trig     <= is_trig_nxt;
            gap_cnt     <= gap_cnt_nxt;
            good_cnt    <= good_cnt_nxt;
            trigger_out <= trigger_nxt;
            frame_ok    <= frame_ok_nxt;
            frame_err   <= frame_err_nxt;
            locked      <= locked_nxt;
            trig_count  <= trig_count_nxt;
            err_count   <= err_count_nxt;
        end
    end

    // Pulses are decided here and registered, so they appear one cycle after the deciding edge.
    always_comb begin
        state_nxt     = state;
        byte_idx_nxt  = byte_idx;
        csum_nxt      = csum;
        is_trig_nxt   = is_trig;
        gap_cnt_nxt   = gap_cnt;
        trigger_nxt   = 1'b0;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            HUNT: begin
                gap_cnt_nxt = '0;
                if (rx_valid && (rx_data == IDLE_HDR || rx_data == TRIG_HDR)) begin
                    state_nxt    = RECV;
                    byte_idx_nxt = IDX_W'(1);
                    csum_nxt     = rx_data;
                    is_trig_nxt  = (rx_data == TRIG_HDR);
                end
            end
            RECV: begin
                if (rx_valid) begin
                    gap_cnt_nxt = '0;
                    if (byte_idx == LAST_IDX) begin
                        state_nxt    = HUNT;
                        byte_idx_nxt = '0;
                        if (rx_data == csum) begin
                            frame_ok_nxt = 1'b1;
                            trigger_nxt  = is_trig;
                        end else begin
                            frame_err_nxt = 1'b1;
                        end
                    end else begin
                        csum_nxt     = csum ^ rx_data;
                        byte_idx_nxt = byte_idx + IDX_W'(1);
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    // This idle cycle is the one that brings the gap to BYTE_TIMEOUT.
                    state_nxt     = HUNT;
                    byte_idx_nxt  = '0;
                    gap_cnt_nxt   = '0;
                    frame_err_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Lock tracking and statistics follow the pulses so they update in the same cycle.
    always_comb begin
        good_cnt_nxt   = good_cnt;
        trig_count_nxt = trig_count;
        err_count_nxt  = err_count;

        if (frame_err_nxt) begin
            good_cnt_nxt = '0;
        end else if (frame_ok_nxt && good_cnt != LOCK_MAX) begin
            good_cnt_nxt = good_cnt + LOCK_W'(1);
        end
        locked_nxt = (good_cnt_nxt == LOCK_MAX);

        if (trigger_nxt) begin
            trig_count_nxt = trig_count + 16'd1;
        end
        if (frame_err_nxt && err_count != 16'hFFFF) begin
            err_count_nxt = err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_psc_trigger_rx.sv
// Table-driven bench for psc_trigger_rx: each row is one clock of stimulus with the
// outputs expected after the edge that samples it.
module tb_psc_trigger_rx;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        trigger_out;
    logic        frame_ok;
    logic        frame_err;
    logic        locked;
    logic [15:0] trig_count;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic        valid;
        logic [7:0]  data;
        logic        exp_trig;
        logic        exp_ok;
        logic        exp_err;
        logic        exp_locked;
        logic [15:0] exp_tc;
        logic [15:0] exp_ec;
    } vec_t;

    vec_t vecs[$];

    psc_trigger_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .trigger_out (trigger_out),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .locked      (locked),
        .trig_count  (trig_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_row(input logic v, input logic [7:0] d, input logic t,
                                    input logic o, input logic e, input logic l,
                                    input int tc, input int ec);
        vecs.push_back('{v, d, t, o, e, l, 16'(tc), 16'(ec)});
    endfunction

    function automatic void add_data(input logic [7:0] d, input logic l, input int tc, input int ec);
        add_row(1'b1, d, 1'b0, 1'b0, 1'b0, l, tc, ec);
    endfunction

    function automatic void add_idle(input int n, input logic l, input int tc, input int ec);
        for (int i = 0; i < n; i++) add_row(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, l, tc, ec);
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one row at a falling edge, then compare once the next rising edge has passed.
    task automatic apply_stimulus(input string tag, input int idx, input vec_t r);
        string p;
        rx_valid = r.valid;
        rx_data  = r.data;
        @(negedge clk);
        p = $sformatf("%s[%0d]", tag, idx);
        check_output({p, ".trigger_out"}, 16'(trigger_out), 16'(r.exp_trig));
        check_output({p, ".frame_ok"},    16'(frame_ok),    16'(r.exp_ok));
        check_output({p, ".frame_err"},   16'(frame_err),   16'(r.exp_err));
        check_output({p, ".locked"},      16'(locked),      16'(r.exp_locked));
        check_output({p, ".trig_count"},  trig_count,       r.exp_tc);
        check_output({p, ".err_count"},   err_count,        r.exp_ec);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(tag, i, vecs[i]);
        vecs.delete();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_output({tag, ".rst_trigger_out"}, 16'(trigger_out), 16'h0);
        check_output({tag, ".rst_frame_ok"},    16'(frame_ok),    16'h0);
        check_output({tag, ".rst_frame_err"},   16'(frame_err),   16'h0);
        check_output({tag, ".rst_locked"},      16'(locked),      16'h0);
        check_output({tag, ".rst_trig_count"},  trig_count,       16'h0);
        check_output({tag, ".rst_err_count"},   err_count,        16'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Trigger frame 5A,01..08 has checksum 5A^08 = 52.
    function automatic void add_trig_body(input logic l, input int tc, input int ec);
        add_data(8'h5A, l, tc, ec);
        for (int b = 1; b <= 8; b++) add_data(8'(b), l, tc, ec);
    endfunction

    function automatic void add_idle_body(input logic l, input int tc, input int ec);
        add_data(8'hA5, l, tc, ec);
        for (int b = 0; b < 8; b++) add_data(8'h00, l, tc, ec);
    endfunction

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        do_reset("init");

        $display("[TB] Test 1: reset mid-frame");
        add_data(8'h5A, 1'b0, 0, 0);
        for (int b = 1; b <= 4; b++) add_data(8'(b), 1'b0, 0, 0);
        run_table("t1a");
        do_reset("t1");
        add_trig_body(1'b0, 0, 0);
        add_row(1'b1, 8'h52, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        add_idle(1, 1'b0, 1, 0);
        run_table("t1b");

        $display("[TB] Test 2: idle frame");
        do_reset("t2");
        add_idle_body(1'b0, 0, 0);
        add_row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        add_idle(2, 1'b0, 0, 0);
        run_table("t2");

        $display("[TB] Test 3: good trigger frame");
        do_reset("t3");
        add_trig_body(1'b0, 0, 0);
        add_row(1'b1, 8'h52, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        add_idle(2, 1'b0, 1, 0);
        run_table("t3");

        $display("[TB] Test 4: bad checksum");
        do_reset("t4");
        add_trig_body(1'b0, 0, 0);
        add_row(1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        add_idle(2, 1'b0, 0, 1);
        run_table("t4");

        $display("[TB] Test 5: inter-byte timeout and its boundary");
        do_reset("t5");
        add_data(8'h5A, 1'b0, 0, 0);
        add_data(8'h01, 1'b0, 0, 0);
        add_data(8'h02, 1'b0, 0, 0);
        add_data(8'h03, 1'b0, 0, 0);
        add_idle(63, 1'b0, 0, 0);
        add_row(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
        add_idle(1, 1'b0, 0, 1);
        add_idle_body(1'b0, 0, 1);
        add_row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        // A byte on the 64th quiet cycle is still accepted.
        add_data(8'h5A, 1'b0, 0, 1);
        add_data(8'h01, 1'b0, 0, 1);
        add_idle(63, 1'b0, 0, 1);
        for (int b = 2; b <= 8; b++) add_data(8'(b), 1'b0, 0, 1);
        add_row(1'b1, 8'h52, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        add_idle(1, 1'b0, 1, 1);
        run_table("t5");

        $display("[TB] Test 6: junk, back-to-back frames, lock and unlock");
        do_reset("t6");
        add_data(8'h00, 1'b0, 0, 0);
        add_data(8'hFF, 1'b0, 0, 0);
        add_idle_body(1'b0, 0, 0);
        add_row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        add_idle_body(1'b0, 0, 0);
        add_row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        add_idle_body(1'b0, 0, 0);
        add_row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        add_trig_body(1'b1, 0, 0);
        add_row(1'b1, 8'h52, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0);
        add_idle_body(1'b1, 1, 0);
        add_row(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        add_idle(2, 1'b0, 1, 1);
        run_table("t6");

        do_reset("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/psc_trigger_rx.md
Name: psc_trigger_rx

Overview:
- Receive-side counterpart of the PSC trigger transmitter.
- Consumes the byte stream from the serial link deserializer and delineates fixed-length frames.
- Classifies each frame as idle or trigger and verifies its checksum.
- Emits a one-cycle trigger pulse to the power-supply control logic for each good trigger frame, plus link-health status (lock, error counts).

Parameters:
- FRAME_BYTES, 10, bytes per frame including header and checksum; must be >= 3.
- IDLE_HDR, 8'hA5, header byte of an idle frame.
- TRIG_HDR, 8'h5A, header byte of a trigger frame.
- BYTE_TIMEOUT, 64, max clk cycles allowed between consecutive bytes inside a frame.
- LOCK_COUNT, 3, consecutive good frames required to assert locked.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- trigger_out  out  1  one-cycle pulse per good trigger frame.
- frame_ok  out  1  one-cycle pulse per frame with good checksum, idle or trigger.
- frame_err  out  1  one-cycle pulse on checksum error or inter-byte timeout.
- locked  out  1  high after LOCK_COUNT consecutive good frames.
- trig_count  out  16  count of trigger_out pulses; wraps 16'hFFFF -> 0.
- err_count  out  16  count of frame_err pulses; saturates at 16'hFFFF.

Behaviour:
- Reset (async, active-high):
  - state=HUNT.
  - All outputs 0; byte index, checksum, gap counter and good-frame counter cleared.
  - Reset mid-frame discards the partial frame; no pulse is generated.
- States: HUNT, RECV.
- HUNT:
  - On rx_valid with rx_data==IDLE_HDR or TRIG_HDR: go to RECV, byte_idx=1, csum=rx_data, is_trig=(rx_data==TRIG_HDR).
  - Any other byte is silently dropped: no error, no count change.
- RECV, on each rx_valid:
  - Clear the gap counter.
  - If byte_idx < FRAME_BYTES-1: csum ^= rx_data, byte_idx++.
  - If byte_idx == FRAME_BYTES-1 (checksum byte), compare rx_data against csum and go to HUNT on the same edge:
    - Match: frame_ok=1 next cycle; trigger_out=1 in the same cycle if is_trig.
    - Mismatch: frame_err=1 next cycle.
- Checksum definition: XOR of bytes 0..FRAME_BYTES-2, header included.
- Latency: pulses appear registered, exactly 1 cycle after the edge that samples the checksum byte. Each pulse is high for exactly 1 cycle.
- Back-to-back frames: a header on the cycle immediately after the checksum byte is accepted with no gap.
- Timeout:
  - In RECV, the gap counter increments on every cycle without rx_valid.
  - When it reaches BYTE_TIMEOUT: frame_err pulse next cycle, state -> HUNT, partial frame discarded.
  - If rx_valid arrives on the cycle the counter would reach BYTE_TIMEOUT, the byte is accepted and no timeout occurs.
  - The gap counter is held at 0 in HUNT.
- Lock:
  - The good-frame counter increments on each frame_ok and saturates at LOCK_COUNT.
  - locked=1 while counter==LOCK_COUNT, updated on the same cycle as the frame_ok pulse.
  - Any frame_err clears the counter and deasserts locked on the same cycle as the frame_err pulse.
- Counters:
  - trig_count increments on the same cycle as the trigger_out pulse.
  - err_count increments on the same cycle as the frame_err pulse.
- trigger_out, frame_ok and frame_err are never asserted on the same cycle except trigger_out together with frame_ok.

Test Plan:
1. Assert reset mid-trigger-frame (header 5A + 4 bytes), then release -> all outputs 0, state HUNT; a following complete good trigger frame gives trig_count=1.
2. Idle frame A5, 00x8, checksum A5 -> frame_ok pulses 1 cycle after the checksum byte for 1 cycle; trigger_out stays 0; trig_count=0.
3. Trigger frame 5A, 01..08, checksum 52 -> trigger_out and frame_ok pulse together 1 cycle after the checksum byte; trig_count=1; err_count=0.
4. Trigger frame 5A, 01..08, checksum 53 -> frame_err pulse, no trigger_out, err_count=1, locked=0.
5. Send 5A, 01, 02, 03, then idle for 64 cycles -> frame_err pulse after the 64th idle cycle, err_count increments; the next A5 header starts a new frame that completes with frame_ok.
6. Send bytes 00, FF in HUNT, then 3 back-to-back good idle frames -> junk produces no pulses; locked=1 coincident with the third frame_ok; a subsequent bad checksum drops locked=0.
